pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports listed in the table below.
REQ-002 Port list, clock and reset first:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous reset, active high
- id_valid  in  1  ID stage holds an instruction
- id_rs1  in  4  first source register
- id_rs1_en  in  1  rs1 is read
- id_rs2  in  4  second source register
- id_rs2_en  in  1  rs2 is read
- id_rd  in  4  destination register
- id_regwrite  in  1  instruction writes id_rd
- id_memtoreg  in  1  instruction is a load
- ex_branch  in  1  EX holds a conditional branch
- ex_zero  in  1  EX condition result (1 = taken)
- ex_jump  in  1  EX holds an unconditional jump
- mem_busy  in  1  data memory not ready; pipeline frozen
- issue  out  1  ID instruction advances to EX this cycle
- stall  out  1  ID held by data hazard
- flush_if  out  1  squash IF-stage instruction
- flush_id  out  1  squash ID-stage instruction
- pc_sel  out  1  1 = load PC from EX target
- busy_mask  out  16  bit n set = register n has a pending write
- stall_cnt  out  16  hazard-stall cycles, saturating

Function
REQ-003 The FSM SHALL have three states: RUN, FLUSH and HOLD.
REQ-004 Priority within a cycle SHALL be: rst, then mem_busy, then taken, then hazard.
REQ-005 taken SHALL equal (ex_branch AND ex_zero) OR ex_jump, and SHALL be evaluated only in RUN.
REQ-006 Transitions SHALL be:
- any state with mem_busy=1 -> HOLD
- HOLD with mem_busy=0 -> RUN
- RUN with taken -> FLUSH
- FLUSH -> RUN unconditionally (ex_* ignored, since EX holds a bubble)
REQ-007 In RUN with taken and mem_busy=0:
- pc_sel=1, flush_if=1, flush_id=1
- issue=0, stall=0
REQ-008 In FLUSH:
- flush_id=1
- pc_sel=0, flush_if=0, issue=0, stall=0
REQ-009 In HOLD:
- all of issue, stall, flush_if, flush_id and pc_sel SHALL be 0
- scoreboard counters and stall_cnt SHALL hold their values
REQ-010 A taken event coinciding with mem_busy=1 SHALL be ignored; the frozen EX instruction SHALL present it again after HOLD.
REQ-011 The scoreboard SHALL hold a 2-bit countdown per register, r0..r15; r0 is not special.
REQ-012 hazard SHALL equal (id_rs1_en AND cnt[id_rs1]!=0) OR (id_rs2_en AND cnt[id_rs2]!=0).
REQ-013 issue SHALL equal RUN AND NOT mem_busy AND NOT taken AND id_valid AND NOT hazard.
REQ-014 stall SHALL equal RUN AND NOT mem_busy AND NOT taken AND id_valid AND hazard.
REQ-015 Each non-zero counter SHALL decrement by 1 per cycle when mem_busy=0.
REQ-016 On issue with id_regwrite=1, cnt[id_rd] SHALL load 3 if id_memtoreg=1, else 2; the load SHALL override that register's decrement and any existing value.
REQ-017 An instruction whose rs equals its own rd SHALL check the hazard against the pre-issue counter value.
REQ-018 busy_mask[n] SHALL equal (cnt[n]!=0), taken from registered state.
REQ-019 stall_cnt SHALL increment on each cycle with stall=1 and SHALL saturate at 0xFFFF.
REQ-020 All outputs except busy_mask and stall_cnt SHALL be combinational from state and inputs; latency from a taken event to pc_sel SHALL be 0 cycles.

Reset
REQ-021 On rst=1 at a clock edge, the block SHALL set state=RUN, all counters=0, busy_mask=0 and stall_cnt=0.
REQ-022 While rst=1, all outputs SHALL read 0.
REQ-023 Reset SHALL override HOLD and FLUSH mid-operation.

Verification
REQ-024 Bench SHALL cover: load r5 issued; next cycle id_rs1=5 -> stall=1 for 2 cycles, issue=1 on the 3rd cycle, stall_cnt=2.
REQ-025 Bench SHALL cover: ALU write r3, then dependent reading r3 -> stall=1 for 1 cycle, busy_mask=0x0008 then 0x0000.
REQ-026 Bench SHALL cover: ex_branch=1, ex_zero=1 in RUN -> pc_sel, flush_if, flush_id =1 for that cycle, then flush_id=1 alone for 1 cycle, then RUN.
REQ-027 Bench SHALL cover: mem_busy=1 for 4 cycles with r7 counter=2 and ex_jump=1 -> no pc_sel during HOLD, counter still 2; jump taken in the first cycle after mem_busy falls.
REQ-028 Bench SHALL cover: rst asserted in FLUSH with busy_mask=0x0021 -> next cycle state RUN, busy_mask=0, stall_cnt=0, all outputs 0.
REQ-029 Bench SHALL cover: stall_cnt preset near 0xFFFF by sustained hazard -> holds 0xFFFF, no wrap to 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush controller: RUN/FLUSH/HOLD sequencing, per-register
// write-pending scoreboard, and a saturating count of hazard-stall cycles.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_rs1,
  input  logic        id_rs1_en,
  input  logic [3:0]  id_rs2,
  input  logic        id_rs2_en,
  input  logic [3:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memtoreg,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic        ex_jump,
  input  logic        mem_busy,
  output logic        issue,
  output logic        stall,
  output logic        flush_if,
  output logic        flush_id,
  output logic        pc_sel,
  output logic [15:0] busy_mask,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [1:0]  r_cnt [16];
  logic [15:0] r_stall_cnt;
  logic [15:0] w_busy;
  logic        w_taken, w_hazard, w_run, w_frozen, w_issue, w_stall;

  assign w_taken  = (ex_branch && ex_zero) || ex_jump;
  // Hazard looks at the counters before this cycle's own write lands.
  assign w_hazard = (id_rs1_en && (r_cnt[id_rs1] != 2'd0)) ||
                    (id_rs2_en && (r_cnt[id_rs2] != 2'd0));
  assign w_run    = (r_state == S_RUN) && !mem_busy;
  assign w_issue  = w_run && !w_taken && id_valid && !w_hazard;
  assign w_stall  = w_run && !w_taken && id_valid && w_hazard;
  // The cycle spent in HOLD after mem_busy drops stays frozen as well.
  assign w_frozen = mem_busy || (r_state == S_HOLD);

  always_comb begin
    w_busy = '0;
    for (int n = 0; n < 16; n++) w_busy[n] = (r_cnt[n] != 2'd0);
  end

  always_comb begin
    w_next = S_RUN;
    if (mem_busy)                            w_next = S_HOLD;
    else if ((r_state == S_RUN) && w_taken)  w_next = S_FLUSH;
  end

  assign issue     = !rst && w_issue;
  assign stall     = !rst && w_stall;
  assign pc_sel    = !rst && w_run && w_taken;
  assign flush_if  = !rst && w_run && w_taken;
  assign flush_id  = !rst && ((w_run && w_taken) || (r_state == S_FLUSH));
  assign busy_mask = rst ? 16'h0000 : w_busy;
  assign stall_cnt = rst ? 16'h0000 : r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_stall_cnt <= 16'h0000;
      for (int n = 0; n < 16; n++) r_cnt[n] <= 2'd0;
    end else begin
      r_state <= w_next;
      if (!w_frozen) begin
        for (int n = 0; n < 16; n++) begin
          if (w_issue && id_regwrite && (id_rd == 4'(n)))
            r_cnt[n] <= id_memtoreg ? 2'd3 : 2'd2;
          else if (r_cnt[n] != 2'd0)
            r_cnt[n] <= r_cnt[n] - 2'd1;
        end
        if (w_stall && (r_stall_cnt != 16'hFFFF))
          r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule
